// File: rtl/can_rx_destuff_if.sv
// Bus-side signal bundle for the CAN receive path with bit destuffing.
// The slave modport is the receiver; the master modport is whoever drives the line.
interface can_rx_destuff_if #(
    parameter int FRAME_BITS = 108
);
    logic                  i_Rx_Serial;
    logic                  o_Rx_DV;
    logic [0:FRAME_BITS-1] o_Rx_Frame;
    logic                  o_Ignora_Bit;
    logic                  o_Erro_Stuffing;

    modport master (
        output i_Rx_Serial,
        input  o_Rx_DV,
        input  o_Rx_Frame,
        input  o_Ignora_Bit,
        input  o_Erro_Stuffing
    );

    modport slave (
        input  i_Rx_Serial,
        output o_Rx_DV,
        output o_Rx_Frame,
        output o_Ignora_Bit,
        output o_Erro_Stuffing
    );
endinterface

// File: rtl/can_rx_destuff.sv
// CAN bit receiver: mid-bit sampling, stuff-bit removal and error flagging, frame assembly.
// Define CAN_RX_RESYNC_EN to realign the bit phase on every falling edge while receiving.
module can_rx_destuff #(
    parameter int CLKS_PER_BIT = 10,
    parameter int FRAME_BITS   = 108,
    parameter int STUFF_LEN    = 5
) (
    input  logic            i_Clock,
    input  logic            i_Rst_n,
    can_rx_destuff_if.slave bus
);
    localparam int PH_W  = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(FRAME_BITS + 1);
    localparam int RUN_W = $clog2(STUFF_LEN + 1);

    localparam logic [PH_W-1:0]  SAMPLE_PH = PH_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] FULL_IDX  = IDX_W'(FRAME_BITS);
    localparam logic [RUN_W-1:0] STUFF_RUN = RUN_W'(STUFF_LEN);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        DONE
    } state_t;

    state_t                r_State;
    state_t                w_State_Next;
    logic [PH_W-1:0]       r_Phase;
    logic [PH_W-1:0]       w_Phase_Next;
    logic [IDX_W-1:0]      r_Index;
    logic [IDX_W-1:0]      w_Index_Next;
    logic [RUN_W-1:0]      r_Run;
    logic [RUN_W-1:0]      w_Run_Next;
    logic                  r_Prev_Bit;
    logic                  w_Prev_Next;
    logic [0:FRAME_BITS-1] r_Frame;
    logic [0:FRAME_BITS-1] w_Frame_Next;
    logic                  r_Rx_DV;
    logic                  w_DV_Next;
    logic                  r_Ignora_Bit;
    logic                  w_Ign_Next;
    logic                  r_Erro_Stuffing;
    logic                  w_Err_Next;

    logic                  r_Rx_Meta;
    logic                  r_Rx_Sync;
    logic                  r_Rx_Last;
    logic                  w_Fall;
    logic                  w_Sample;

    // The bus idles recessive, so the synchronizer resets to 1 to avoid a false SOF edge.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Rx_Meta <= 1'b1;
            r_Rx_Sync <= 1'b1;
            r_Rx_Last <= 1'b1;
        end else begin
            r_Rx_Meta <= bus.i_Rx_Serial;
            r_Rx_Sync <= r_Rx_Meta;
            r_Rx_Last <= r_Rx_Sync;
        end
    end

    assign w_Fall   = r_Rx_Last & ~r_Rx_Sync;
    assign w_Sample = (r_State == RECV) && (r_Phase == SAMPLE_PH);

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State         <= IDLE;
            r_Phase         <= '0;
            r_Index         <= '0;
            r_Run           <= '0;
            r_Prev_Bit      <= 1'b0;
            r_Frame         <= '1;
            r_Rx_DV         <= 1'b0;
            r_Ignora_Bit    <= 1'b0;
            r_Erro_Stuffing <= 1'b0;
        end else begin
            r_State         <= w_State_Next;
            r_Phase         <= w_Phase_Next;
            r_Index         <= w_Index_Next;
            r_Run           <= w_Run_Next;
            r_Prev_Bit      <= w_Prev_Next;
            r_Frame         <= w_Frame_Next;
            r_Rx_DV         <= w_DV_Next;
            r_Ignora_Bit    <= w_Ign_Next;
            r_Erro_Stuffing <= w_Err_Next;
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Phase_Next = r_Phase;
        w_Index_Next = r_Index;
        w_Run_Next   = r_Run;
        w_Prev_Next  = r_Prev_Bit;
        w_Frame_Next = r_Frame;
        w_DV_Next    = 1'b0;
        w_Ign_Next   = 1'b0;
        w_Err_Next   = 1'b0;

        case (r_State)
            IDLE: begin
                if (w_Fall) begin
                    w_Phase_Next = '0;
                    w_Frame_Next = '1;
                    w_Index_Next = '0;
                    w_Run_Next   = '0;
                    w_State_Next = RECV;
                end
            end

            RECV: begin
                w_Phase_Next = (r_Phase == LAST_PH) ? '0 : r_Phase + PH_W'(1);
`ifdef CAN_RX_RESYNC_EN
                if (w_Fall) begin
                    w_Phase_Next = '0;
                end
`endif
                if (w_Sample) begin
                    // A full run means this bit must differ; equal recessive bits mark end of frame.
                    if (r_Run == STUFF_RUN) begin
                        if (r_Rx_Sync != r_Prev_Bit) begin
                            w_Ign_Next  = 1'b1;
                            w_Prev_Next = r_Rx_Sync;
                            w_Run_Next  = RUN_W'(1);
                        end else if (!r_Rx_Sync) begin
                            w_Err_Next   = 1'b1;
                            w_State_Next = IDLE;
                        end else begin
                            if (r_Index < FULL_IDX) begin
                                w_Frame_Next[r_Index] = r_Rx_Sync;
                                w_Index_Next          = r_Index + IDX_W'(1);
                            end
                            w_DV_Next    = 1'b1;
                            w_State_Next = DONE;
                        end
                    end else begin
                        if (r_Index < FULL_IDX) begin
                            w_Frame_Next[r_Index] = r_Rx_Sync;
                            w_Index_Next          = r_Index + IDX_W'(1);
                        end
                        w_Run_Next  = ((r_Run != '0) && (r_Rx_Sync == r_Prev_Bit)) ?
                                      r_Run + RUN_W'(1) : RUN_W'(1);
                        w_Prev_Next = r_Rx_Sync;
                        if ((r_Index + IDX_W'(1)) >= FULL_IDX) begin
                            w_DV_Next    = 1'b1;
                            w_State_Next = DONE;
                        end
                    end
                end
            end

            DONE: begin
                if (r_Rx_Sync) begin
                    w_State_Next = IDLE;
                end
            end

            default: begin
                w_State_Next = IDLE;
            end
        endcase
    end

    assign bus.o_Rx_DV         = r_Rx_DV;
    assign bus.o_Rx_Frame      = r_Frame;
    assign bus.o_Ignora_Bit    = r_Ignora_Bit;
    assign bus.o_Erro_Stuffing = r_Erro_Stuffing;
endmodule

// File: tb/tb_can_rx_destuff.sv
// Bench for can_rx_destuff: directed and random bus frames, compared cycle by cycle
// against a bit-level reference model of the destuffing rules.
module tb_can_rx_destuff;
    localparam int FB  = 108;
    localparam int CPB = 10;
    localparam int SL  = 5;

    typedef struct {
        int            cyc;
        logic [2:0]    kind;
        bit            chkFrame;
        logic [0:FB-1] frame;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   nCompared = 0;
    int   nMismatched = 0;

    ev_t           evQ[$];
    bit            rawQ[$];
    int            mEvBit[$];
    logic [2:0]    mEvKind[$];
    int            mStop;
    logic [0:FB-1] mFrame;
    logic [0:FB-1] altPat;

    can_rx_destuff_if #(.FRAME_BITS(FB)) bus();

    can_rx_destuff #(
        .CLKS_PER_BIT(CPB),
        .FRAME_BITS  (FB),
        .STUFF_LEN   (SL)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    always #50 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event kinds are {valid, stuff bit, stuff error}.
    task automatic runModel();
        int  run;
        bit  prev;
        int  idx;
        run  = 0;
        prev = 1'b0;
        idx  = 0;
        mFrame = '1;
        mStop  = -1;
        mEvBit.delete();
        mEvKind.delete();
        for (int n = 0; n < rawQ.size(); n++) begin
            bit b;
            b = rawQ[n];
            if (run == SL && b != prev) begin
                mEvBit.push_back(n);
                mEvKind.push_back(3'b010);
                prev = b;
                run  = 1;
            end else if (run == SL && b == 1'b0) begin
                mEvBit.push_back(n);
                mEvKind.push_back(3'b001);
                mStop = n;
                break;
            end else if (run == SL) begin
                if (idx < FB) mFrame[idx] = b;
                mEvBit.push_back(n);
                mEvKind.push_back(3'b100);
                mStop = n;
                break;
            end else begin
                mFrame[idx] = b;
                idx++;
                run  = (run > 0 && b == prev) ? run + 1 : 1;
                prev = b;
                if (idx == FB) begin
                    mEvBit.push_back(n);
                    mEvKind.push_back(3'b100);
                    mStop = n;
                    break;
                end
            end
        end
    endtask

    task automatic loadPattern(input logic [127:0] pat, input int n);
        rawQ.delete();
        for (int i = 0; i < n; i++) rawQ.push_back(pat[n-1-i]);
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse for line bit n is registered 8 clocks after SOF is driven, then every bit time.
    task automatic applyStimulus(input int nBits, input int idleBits);
        int c0;
        @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < mEvBit.size(); k++) begin
            if (mEvBit[k] < nBits) begin
                ev_t e;
                e.cyc      = c0 + 8 + CPB * mEvBit[k];
                e.kind     = mEvKind[k];
                e.chkFrame = (mEvKind[k] != 3'b010);
                e.frame    = mFrame;
                evQ.push_back(e);
            end
        end
        for (int n = 0; n < nBits; n++) begin
            bus.i_Rx_Serial = rawQ[n];
            repeat (CPB) @(negedge clk);
        end
        bus.i_Rx_Serial = 1'b1;
        repeat (CPB * idleBits) @(negedge clk);
        if (mStop >= 0 && mStop < nBits)
            checkOutput("frame_hold", bus.o_Rx_Frame, mFrame);
    endtask

    always @(negedge clk) begin : compare
        logic [2:0] expK;
        logic [2:0] actK;
        expK = 3'b000;
        actK = {bus.o_Rx_DV, bus.o_Ignora_Bit, bus.o_Erro_Stuffing};
        if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
            expK = evQ[0].kind;
            if (evQ[0].chkFrame) begin
                nCompared++;
                if (bus.o_Rx_Frame !== evQ[0].frame) begin
                    nMismatched++;
                    $display("[TB] FAIL event_frame at cyc %0d: got %h expected %h",
                             cyc, bus.o_Rx_Frame, evQ[0].frame);
                end
            end
            void'(evQ.pop_front());
        end
        nCompared++;
        if (actK !== expK) begin
            nMismatched++;
            $display("[TB] FAIL pulses at cyc %0d: got dv/ign/err=%b expected %b", cyc, actK, expK);
        end
        if (!rst_n) begin
            nCompared++;
            if (bus.o_Rx_Frame !== {FB{1'b1}}) begin
                nMismatched++;
                $display("[TB] FAIL reset_frame at cyc %0d: got %h expected all ones", cyc, bus.o_Rx_Frame);
            end
        end
    end

    initial begin
        bus.i_Rx_Serial = 1'b1;
        for (int i = 0; i < FB; i++) altPat[i] = i[0];

        $display("[TB] reset with toggling line");
        repeat (20) begin
            @(negedge clk);
            bus.i_Rx_Serial = 1'($urandom_range(0, 1));
        end
        checkOutput("reset_frame_ones", bus.o_Rx_Frame, {FB{1'b1}});
        @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        checkOutput("idle_after_reset", bus.o_Rx_Frame, {FB{1'b1}});

        $display("[TB] stuff bit frame");
        loadPattern(128'b0000010111111, 13);
        runModel();
        checkOutput("pin_stuff_bit", 128'(mEvBit[0]), 128'd5);
        checkOutput("pin_stuff_kind", 128'(mEvKind[0]), 128'b010);
        checkOutput("pin_stuff_frame", 128'(mFrame[0:5]), 128'b000000);
        checkOutput("pin_stuff_stop", 128'(mStop), 128'd12);
        applyStimulus(mStop + 1, 3);

        $display("[TB] stuff error frame");
        loadPattern(128'b000000, 6);
        runModel();
        checkOutput("pin_err_stop", 128'(mStop), 128'd5);
        checkOutput("pin_err_kind", 128'(mEvKind[0]), 128'b001);
        applyStimulus(mStop + 1, 3);

        $display("[TB] end of frame run");
        loadPattern(128'b010100111111, 12);
        runModel();
        checkOutput("pin_eof_stop", 128'(mStop), 128'd11);
        checkOutput("pin_eof_kind", 128'(mEvKind[0]), 128'b100);
        checkOutput("pin_eof_frame", 128'(mFrame), 128'({12'b010100111111, {96{1'b1}}}));
        applyStimulus(mStop + 1, 3);

        $display("[TB] full capacity frame");
        rawQ.delete();
        for (int i = 0; i < FB; i++) rawQ.push_back(i[0]);
        runModel();
        checkOutput("pin_cap_stop", 128'(mStop), 128'd107);
        checkOutput("pin_cap_frame", 128'(mFrame), 128'(altPat));
        applyStimulus(mStop + 1, 3);

        $display("[TB] reset mid-frame");
        applyStimulus(20, 0);
        bus.i_Rx_Serial = 1'b0;
        repeat (4) @(negedge clk);
        #10 rst_n = 1'b0;
        evQ.delete();
        #1;
        checkOutput("midreset_pulses", 128'({bus.o_Rx_DV, bus.o_Ignora_Bit, bus.o_Erro_Stuffing}), 128'b000);
        checkOutput("midreset_frame", bus.o_Rx_Frame, {FB{1'b1}});
        @(negedge clk);
        bus.i_Rx_Serial = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        loadPattern(128'b010100111111, 12);
        runModel();
        applyStimulus(mStop + 1, 3);

        $display("[TB] random frames");
        for (int f = 0; f < 16; f++) begin
            bit v;
            v = 1'b0;
            rawQ.delete();
            while (rawQ.size() < 300) begin
                int len;
                len = ($urandom_range(0, 19) == 0) ? 6 : int'($urandom_range(1, 5));
                repeat (len) rawQ.push_back(v);
                v = ~v;
            end
            runModel();
            if (mStop < 0) begin
                nCompared++;
                nMismatched++;
                $display("[TB] FAIL model_stop: got %0d expected a stop bit", mStop);
            end else begin
                applyStimulus(mStop + 1, 3);
            end
        end

        repeat (20) @(negedge clk);
        checkOutput("events_drained", 128'(evQ.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
